// File: rtl/mpu_pkg.sv
// Shared definitions for the mips_mpu core and its program/run/dump controller.
// Core geometry defaults live here so the core and the controller agree.
package mpu_pkg;

    localparam int DEF_OPCODE_WIDTH = 25;
    localparam int DEF_OPCODE_COUNT = 64;
    localparam int DEF_REG_WIDTH    = 128;
    localparam int DEF_REG_COUNT    = 32;

    typedef enum logic [1:0] {
        LOAD       = 2'd0,
        WAIT_START = 2'd1,
        RUN        = 2'd2,
        DUMP       = 2'd3
    } mpu_state_t;

endpackage

// File: rtl/mpu_dump_ser.sv
// Serialises a wrapping range of core registers into DUMP_WIDTH beats,
// least-significant slice first, behind a registered valid/ready output.
module mpu_dump_ser #(
    parameter int REG_WIDTH  = 128,
    parameter int REG_COUNT  = 32,
    parameter int DUMP_WIDTH = 32,
    parameter int RW         = $clog2(REG_COUNT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           go,
    input  logic [RW-1:0]                  first,
    input  logic [RW:0]                    count,
    input  logic [REG_WIDTH*REG_COUNT-1:0] reg_data_in,
    input  logic                           m_ready,
    output logic                           m_valid,
    output logic [DUMP_WIDTH-1:0]          m_data,
    output logic [RW-1:0]                  m_reg,
    output logic                           m_last,
    output logic                           fin
);

    localparam int BEATS = REG_WIDTH / DUMP_WIDTH;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORDS = REG_COUNT * BEATS;
    localparam int WIW   = (WORDS > 1) ? $clog2(WORDS) : 1;

    logic [DUMP_WIDTH-1:0] words [WORDS];
    logic [BW-1:0]         cur_beat, nxt_beat;
    logic [RW:0]           cur_rem, nxt_rem;
    logic [RW-1:0]         nxt_reg;
    logic                  nxt_last;
    logic [WIW-1:0]        word_idx;
    logic                  hs, load_go, advance;

    for (genvar i = 0; i < WORDS; i++) begin : g_words
        assign words[i] = reg_data_in[DUMP_WIDTH*i +: DUMP_WIDTH];
    end

    assign hs      = m_valid & m_ready;
    assign load_go = go && (count != '0);
    assign advance = hs && !m_last;
    assign fin     = (go && (count == '0)) || (hs && m_last);

    // cur_rem counts registers still to send, including the one on the output
    always_comb begin
        nxt_reg  = m_reg;
        nxt_beat = cur_beat + BW'(1);
        nxt_rem  = cur_rem;
        if (cur_beat == BW'(BEATS - 1)) begin
            nxt_beat = '0;
            nxt_reg  = (m_reg == RW'(REG_COUNT - 1)) ? '0 : m_reg + RW'(1);
            nxt_rem  = cur_rem - (RW+1)'(1);
        end
        if (go) begin
            nxt_reg  = first;
            nxt_beat = '0;
            nxt_rem  = count;
        end
        nxt_last = (nxt_rem == (RW+1)'(1)) && (nxt_beat == BW'(BEATS - 1));
        word_idx = WIW'(int'(nxt_reg) * BEATS + int'(nxt_beat));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_reg    <= '0;
            m_last   <= 1'b0;
            cur_beat <= '0;
            cur_rem  <= '0;
        end else if (load_go || advance) begin
            m_valid  <= 1'b1;
            m_data   <= words[word_idx];
            m_reg    <= nxt_reg;
            m_last   <= nxt_last;
            cur_beat <= nxt_beat;
            cur_rem  <= nxt_rem;
        end else if (hs) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/mpu_prog_ctrl.sv
// Program-load, timed run and register-dump sequencer for the mips_mpu core.
//   state      | meaning
//   LOAD       | core held in reset, instruction stream written to imem
//   WAIT_START | program resident, core stalled, waiting for start
//   RUN        | core released for the latched number of cycles
//   DUMP       | core stalled, selected registers streamed out
module mpu_prog_ctrl
    import mpu_pkg::*;
#(
    parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
    parameter int OPCODE_COUNT = DEF_OPCODE_COUNT,
    parameter int REG_WIDTH    = DEF_REG_WIDTH,
    parameter int REG_COUNT    = DEF_REG_COUNT,
    parameter int DUMP_WIDTH   = 32,
    parameter int CYC_WIDTH    = 16,
    localparam int AW          = $clog2(OPCODE_COUNT),
    localparam int RW          = $clog2(REG_COUNT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           s_inst_valid,
    output logic                           s_inst_ready,
    input  logic [OPCODE_WIDTH-1:0]        s_inst_data,
    input  logic                           s_inst_last,
    input  logic                           start,
    input  logic [CYC_WIDTH-1:0]           run_cycles,
    input  logic [RW-1:0]                  dump_first,
    input  logic [RW:0]                    dump_count,
    output logic                           write_inst_en,
    output logic [AW-1:0]                  write_inst_addr,
    output logic [OPCODE_WIDTH-1:0]        write_inst_data,
    output logic                           core_reset,
    output logic                           core_stall,
    input  logic [REG_WIDTH*REG_COUNT-1:0] reg_data_in,
    output logic                           m_dump_valid,
    input  logic                           m_dump_ready,
    output logic [DUMP_WIDTH-1:0]          m_dump_data,
    output logic [RW-1:0]                  m_dump_reg,
    output logic                           m_dump_last,
    output logic [AW:0]                    prog_len,
    output logic                           overflow_err,
    output logic                           done
);

    mpu_state_t           state, state_n;
    logic [CYC_WIDTH-1:0] cyc_cnt;
    logic [RW-1:0]        first_q;
    logic [RW:0]          count_q, count_sat;
    logic                 dump_go, dump_go_n, ser_fin;
    logic                 beat_acc, mem_full;

    assign s_inst_ready = (state == LOAD);
    assign core_reset   = (state == LOAD);
    assign core_stall   = (state != RUN);
    assign beat_acc     = s_inst_valid && s_inst_ready;
    assign mem_full     = (prog_len == (AW+1)'(OPCODE_COUNT));
    assign count_sat    = (dump_count > (RW+1)'(REG_COUNT)) ? (RW+1)'(REG_COUNT) : dump_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:       if (beat_acc && s_inst_last) state_n = WAIT_START;
            WAIT_START: if (start) state_n = (run_cycles == '0) ? DUMP : RUN;
            RUN:        if (cyc_cnt == CYC_WIDTH'(1)) state_n = DUMP;
            DUMP:       if (ser_fin) state_n = WAIT_START;
            default:    state_n = LOAD;
        endcase
        // serializer is kicked in the first DUMP cycle, once the core is frozen
        dump_go_n = (state_n == DUMP) && (state != DUMP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_inst_en   <= 1'b0;
            write_inst_addr <= '0;
            write_inst_data <= '0;
            prog_len        <= '0;
            overflow_err    <= 1'b0;
            cyc_cnt         <= '0;
            first_q         <= '0;
            count_q         <= '0;
            dump_go         <= 1'b0;
            done            <= 1'b0;
        end else begin
            write_inst_en <= 1'b0;
            dump_go       <= dump_go_n;
            done          <= (state == DUMP) && ser_fin;
            if (beat_acc) begin
                if (mem_full) begin
                    overflow_err <= 1'b1;
                end else begin
                    write_inst_en   <= 1'b1;
                    write_inst_addr <= prog_len[AW-1:0];
                    write_inst_data <= s_inst_data;
                    prog_len        <= prog_len + (AW+1)'(1);
                end
            end
            if ((state == WAIT_START) && start) begin
                cyc_cnt <= run_cycles;
                first_q <= dump_first;
                count_q <= count_sat;
            end else if (state == RUN) begin
                cyc_cnt <= cyc_cnt - CYC_WIDTH'(1);
            end
        end
    end

    mpu_dump_ser #(
        .REG_WIDTH  (REG_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .DUMP_WIDTH (DUMP_WIDTH),
        .RW         (RW)
    ) u_dump_ser (
        .clk         (clk),
        .reset       (reset),
        .go          (dump_go),
        .first       (first_q),
        .count       (count_q),
        .reg_data_in (reg_data_in),
        .m_ready     (m_dump_ready),
        .m_valid     (m_dump_valid),
        .m_data      (m_dump_data),
        .m_reg       (m_dump_reg),
        .m_last      (m_dump_last),
        .fin         (ser_fin)
    );

endmodule

// File: tb/tb_mpu_prog_ctrl.sv
// Scenario bench for mpu_prog_ctrl: imem writes and dump beats are checked
// against queues filled from the bench's own model as stimulus is applied.
module tb_mpu_prog_ctrl;

    localparam int OW = 25;
    localparam int OC = 64;
    localparam int RWD = 128;
    localparam int RC = 32;
    localparam int DW = 32;
    localparam int CW = 16;
    localparam int AW = 6;
    localparam int RW = 5;
    localparam int BEATS = RWD / DW;

    logic clk = 1'b0;
    logic reset;
    logic s_inst_valid, s_inst_ready, s_inst_last;
    logic [OW-1:0] s_inst_data;
    logic start;
    logic [CW-1:0] run_cycles;
    logic [RW-1:0] dump_first;
    logic [RW:0] dump_count;
    logic write_inst_en;
    logic [AW-1:0] write_inst_addr;
    logic [OW-1:0] write_inst_data;
    logic core_reset, core_stall;
    logic [RWD*RC-1:0] reg_data_in;
    logic m_dump_valid, m_dump_ready, m_dump_last;
    logic [DW-1:0] m_dump_data;
    logic [RW-1:0] m_dump_reg;
    logic [AW:0] prog_len;
    logic overflow_err, done;

    int total = 0;
    int bad = 0;
    logic [AW+OW-1:0] wq[$];
    logic [RW+DW-1:0] dq[$];
    logic [RWD-1:0] regs [RC];

    always #5 clk = ~clk;

    mpu_prog_ctrl dut (
        .clk(clk), .reset(reset),
        .s_inst_valid(s_inst_valid), .s_inst_ready(s_inst_ready),
        .s_inst_data(s_inst_data), .s_inst_last(s_inst_last),
        .start(start), .run_cycles(run_cycles),
        .dump_first(dump_first), .dump_count(dump_count),
        .write_inst_en(write_inst_en), .write_inst_addr(write_inst_addr),
        .write_inst_data(write_inst_data),
        .core_reset(core_reset), .core_stall(core_stall),
        .reg_data_in(reg_data_in),
        .m_dump_valid(m_dump_valid), .m_dump_ready(m_dump_ready),
        .m_dump_data(m_dump_data), .m_dump_reg(m_dump_reg),
        .m_dump_last(m_dump_last),
        .prog_len(prog_len), .overflow_err(overflow_err), .done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        total++;
        if ({s_inst_ready, core_reset, core_stall} !== 3'b111) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=111", {s_inst_ready, core_reset, core_stall});
        end
        total++;
        if ({write_inst_en, m_dump_valid, m_dump_last, overflow_err, done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {write_inst_en, m_dump_valid, m_dump_last, overflow_err, done});
        end
        total++;
        if (prog_len !== '0) begin
            bad++;
            $display("FAIL reset_prog_len got=%0d exp=0", prog_len);
        end
        reset = 1'b0;
    endtask

    task automatic test_load;
        int writes = 0;
        logic [AW+OW-1:0] exp_w;
        wq.delete();
        for (int i = 0; i < 5; i++) begin
            s_inst_valid = 1'b1;
            s_inst_data  = OW'(32'h0100_0000 + i * 32'h1357);
            s_inst_last  = (i == 4);
            if (s_inst_ready) wq.push_back({AW'(i), s_inst_data});
            tick;
            if (write_inst_en) begin
                writes++;
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL load_extra_write addr=%0d", write_inst_addr);
                end else begin
                    exp_w = wq.pop_front();
                    if ({write_inst_addr, write_inst_data} !== exp_w) begin
                        bad++;
                        $display("FAIL load_write got=%h exp=%h", {write_inst_addr, write_inst_data}, exp_w);
                    end
                end
            end
        end
        s_inst_valid = 1'b0;
        s_inst_last  = 1'b0;
        tick;
        total++;
        if (writes != 5 || write_inst_en !== 1'b0) begin
            bad++;
            $display("FAIL load_write_count got=%0d exp=5 trailing_en=%b", writes, write_inst_en);
        end
        total++;
        if (prog_len !== 7'd5) begin
            bad++;
            $display("FAIL load_prog_len got=%0d exp=5", prog_len);
        end
        total++;
        if ({s_inst_ready, overflow_err, core_reset, core_stall} !== 4'b0001) begin
            bad++;
            $display("FAIL load_after_last got=%b exp=0001",
                     {s_inst_ready, overflow_err, core_reset, core_stall});
        end
    endtask

    task automatic test_overflow;
        int acc = 0;
        int writes = 0;
        logic [AW+OW-1:0] exp_w;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        wq.delete();
        for (int i = 0; i < 70; i++) begin
            s_inst_valid = 1'b1;
            s_inst_data  = OW'($urandom);
            s_inst_last  = (i == 69);
            if (s_inst_ready) begin
                if (acc < OC) wq.push_back({AW'(acc), s_inst_data});
                acc++;
            end
            tick;
            if (write_inst_en) begin
                writes++;
                total++;
                if (wq.size() == 0) begin
                    bad++;
                    $display("FAIL ovf_extra_write addr=%0d", write_inst_addr);
                end else begin
                    exp_w = wq.pop_front();
                    if ({write_inst_addr, write_inst_data} !== exp_w) begin
                        bad++;
                        $display("FAIL ovf_write got=%h exp=%h", {write_inst_addr, write_inst_data}, exp_w);
                    end
                end
            end
            total++;
            if (overflow_err !== (acc > OC)) begin
                bad++;
                $display("FAIL ovf_flag word=%0d got=%b exp=%b", i + 1, overflow_err, acc > OC);
            end
        end
        s_inst_valid = 1'b0;
        s_inst_last  = 1'b0;
        total++;
        if (writes != OC || wq.size() != 0) begin
            bad++;
            $display("FAIL ovf_write_count got=%0d exp=%0d", writes, OC);
        end
        total++;
        if (prog_len !== 7'd64) begin
            bad++;
            $display("FAIL ovf_prog_len got=%0d exp=64", prog_len);
        end
        total++;
        if ({s_inst_ready, core_reset, core_stall} !== 3'b001) begin
            bad++;
            $display("FAIL ovf_wait_start got=%b exp=001", {s_inst_ready, core_reset, core_stall});
        end
    endtask

    task automatic test_run;
        int lo = 0;
        int dones = 0;
        int valids = 0;
        m_dump_ready = 1'b1;
        dump_first = '0;
        dump_count = '0;
        run_cycles = 16'd10;
        start = 1'b1;
        tick;
        start = 1'b0;
        run_cycles = 16'd3;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (core_stall === 1'b0) lo++;
            if (done === 1'b1) dones++;
            if (m_dump_valid === 1'b1) valids++;
            start = (cyc == 3 || cyc == 6);
            tick;
        end
        start = 1'b0;
        total++;
        if (lo != 10) begin
            bad++;
            $display("FAIL run_length got=%0d exp=10", lo);
        end
        total++;
        if (dones != 1 || valids != 0) begin
            bad++;
            $display("FAIL run_zero_dump done_pulses=%0d exp=1 valid_cycles=%0d exp=0", dones, valids);
        end
        total++;
        if ({core_reset, core_stall} !== 2'b01) begin
            bad++;
            $display("FAIL run_end_state got=%b exp=01", {core_reset, core_stall});
        end
    endtask

    task automatic do_dump(input int first, input int count, input int rc, input bit rnd);
        int n, r, beats, dones, extra, exp_beats;
        bit stalled;
        logic [DW-1:0] p_data;
        logic [RW-1:0] p_reg;
        logic p_last;
        logic [RW+DW-1:0] exp_b;
        dq.delete();
        n = (count > RC) ? RC : count;
        for (int k = 0; k < n; k++) begin
            r = (first + k) % RC;
            for (int b = 0; b < BEATS; b++) dq.push_back({RW'(r), regs[r][DW*b +: DW]});
        end
        exp_beats = dq.size();
        beats = 0;
        dones = 0;
        stalled = 1'b0;
        p_data = '0;
        p_reg = '0;
        p_last = 1'b0;
        dump_first = RW'(first);
        dump_count = (RW+1)'(count);
        run_cycles = CW'(rc);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int cyc = 0; cyc < 3000 && !(dq.size() == 0 && dones > 0); cyc++) begin
            if (stalled) begin
                total++;
                if ({m_dump_valid, m_dump_data, m_dump_reg, m_dump_last} !== {1'b1, p_data, p_reg, p_last}) begin
                    bad++;
                    $display("FAIL dump_hold got=%b/%h/%0d/%b exp=1/%h/%0d/%b",
                             m_dump_valid, m_dump_data, m_dump_reg, m_dump_last, p_data, p_reg, p_last);
                end
            end
            if (done === 1'b1) dones++;
            m_dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_dump_valid === 1'b1 && m_dump_ready) begin
                beats++;
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL dump_extra_beat reg=%0d data=%h", m_dump_reg, m_dump_data);
                end else begin
                    exp_b = dq.pop_front();
                    if ({m_dump_reg, m_dump_data} !== exp_b || m_dump_last !== (dq.size() == 0)) begin
                        bad++;
                        $display("FAIL dump_beat got=%h last=%b exp=%h last=%b",
                                 {m_dump_reg, m_dump_data}, m_dump_last, exp_b, dq.size() == 0);
                    end
                end
            end
            stalled = (m_dump_valid === 1'b1) && !m_dump_ready;
            p_data = m_dump_data;
            p_reg = m_dump_reg;
            p_last = m_dump_last;
            tick;
        end
        m_dump_ready = 1'b1;
        total++;
        if (dq.size() != 0 || beats != exp_beats) begin
            bad++;
            $display("FAIL dump_beat_count got=%0d exp=%0d missing=%0d", beats, exp_beats, dq.size());
        end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            if (done === 1'b1) dones++;
            if (m_dump_valid !== 1'b0) extra++;
            tick;
        end
        total++;
        if (dones != 1 || extra != 0) begin
            bad++;
            $display("FAIL dump_done got_pulses=%0d exp=1 trailing_valid=%0d exp=0", dones, extra);
        end
    endtask

    task automatic test_dump_wrap;
        do_dump(30, 3, 0, 1'b0);
    endtask

    task automatic test_backpressure;
        do_dump(29, 5, 4, 1'b1);
    endtask

    task automatic test_dump_zero;
        do_dump(12, 0, 2, 1'b0);
    endtask

    task automatic test_saturate;
        do_dump(7, 40, 1, 1'b0);
    endtask

    task automatic test_reset_mid_dump;
        int waited = 0;
        m_dump_ready = 1'b0;
        dump_first = RW'(3);
        dump_count = (RW+1)'(2);
        run_cycles = '0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (m_dump_valid !== 1'b1 && waited < 20) begin
            tick;
            waited++;
        end
        total++;
        if (m_dump_valid !== 1'b1) begin
            bad++;
            $display("FAIL midrst_no_valid got=%b exp=1", m_dump_valid);
        end
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        m_dump_ready = 1'b1;
        total++;
        if ({m_dump_valid, overflow_err, done, s_inst_ready, core_reset, core_stall} !== 6'b000111) begin
            bad++;
            $display("FAIL midrst_state got=%b exp=000111",
                     {m_dump_valid, overflow_err, done, s_inst_ready, core_reset, core_stall});
        end
        total++;
        if (prog_len !== '0) begin
            bad++;
            $display("FAIL midrst_prog_len got=%0d exp=0", prog_len);
        end
    endtask

    initial begin
        reset = 1'b1;
        s_inst_valid = 1'b0;
        s_inst_data = '0;
        s_inst_last = 1'b0;
        start = 1'b0;
        run_cycles = '0;
        dump_first = '0;
        dump_count = '0;
        m_dump_ready = 1'b1;
        for (int r = 0; r < RC; r++) begin
            for (int b = 0; b < BEATS; b++) regs[r][DW*b +: DW] = {8'(r), 8'(b), 16'($urandom)};
            reg_data_in[RWD*r +: RWD] = regs[r];
        end
        test_reset;
        test_load;
        test_overflow;
        test_run;
        test_dump_wrap;
        test_backpressure;
        test_dump_zero;
        test_saturate;
        test_reset_mid_dump;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
